debug_dump_sink: RTL and testbench

WISHBONE slave that terminates the debug dump stream. It accepts byte writes at the dump data register, buffers them in a small FIFO, and serializes them out as 8N1 UART frames on `txd`. It sits on the shared WISHBONE bus as the responder to the debug dump master, and exposes a status register so software can poll the FIFO state.

---
 rtl/debug_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/debug_dump_sink.sv | 145 ++++++++++++++
 tb/tb_debug_dump_sink.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump sink: TX state encoding, default
// register addresses and status register bit positions.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [29:0] DEF_DATA_ADR = 30'h4000800;
    localparam logic [29:0] DEF_STAT_ADR = 30'h4000801;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop frees the slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     CLK_I,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge CLK_I) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/debug_dump_sink.sv
// WISHBONE slave that buffers debug dump bytes in a FIFO and sends them out
// as 8N1 UART frames on txd.
module debug_dump_sink import debug_pkg::*; #(
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [29:0] DATA_ADR     = DEF_DATA_ADR,
    parameter logic [29:0] STAT_ADR     = DEF_STAT_ADR
) (
    input  logic        CLK_I,
    input  logic        reset_n,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [29:0] ADR_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] slave_DAT_I,
    output logic [31:0] slave_DAT_O,
    output logic        ACK_O,
    output logic        txd,
    output logic        fifo_overflow
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic              request;
    logic              data_hit;
    logic              stat_hit;
    logic              push_req;
    logic              blocked;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              stall_q;
    logic [7:0]        pop_data;
    logic [CNT_W-1:0]  count;
    logic [31:0]       status_word;
    logic              unused_bits;

    tx_state_t         state;
    tx_state_t         state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_q;
    logic              bit_done;

    assign request  = CYC_I & STB_I & ~ACK_O;
    assign data_hit = (ADR_I == DATA_ADR);
    assign stat_hit = (ADR_I == STAT_ADR);
    assign push_req = request & WE_I & data_hit & SEL_I[3];
    // A push into a full FIFO waits without ACK unless the TX pops this edge.
    assign blocked  = push_req & full & ~pop;
    assign push     = push_req & ~blocked;

    assign unused_bits = ^{SEL_I[2:0], slave_DAT_I[23:4], slave_DAT_I[2:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK_I     (CLK_I),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (slave_DAT_I[31:24]),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        status_word                               = '0;
        status_word[STAT_EMPTY_BIT]               = empty;
        status_word[STAT_FULL_BIT]                = full;
        status_word[STAT_BUSY_BIT]                = (state != IDLE);
        status_word[STAT_OVF_BIT]                 = fifo_overflow;
        status_word[STAT_COUNT_LSB +: CNT_W]      = count;
    end

    always_ff @(posedge CLK_I) begin
        if (!reset_n) begin
            ACK_O         <= 1'b0;
            slave_DAT_O   <= '0;
            fifo_overflow <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            ACK_O       <= request & ~blocked;
            slave_DAT_O <= '0;
            stall_q     <= blocked;
            if (request & ~WE_I & stat_hit) slave_DAT_O <= status_word;
            // Master gave up on a stalled push: that byte is gone for good.
            if (stall_q & ~CYC_I)
                fifo_overflow <= 1'b1;
            else if (request & WE_I & stat_hit & slave_DAT_I[STAT_OVF_BIT])
                fifo_overflow <= 1'b0;
        end
    end

    assign bit_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK_I) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE || bit_done) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;
            if (pop) shift_q <= pop_data;
            if (state == IDLE)                 bit_idx <= '0;
            else if (state == DATA && bit_done) bit_idx <= bit_idx + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        txd        = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                txd = shift_q[bit_idx];
                if (bit_done && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (bit_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_dump_sink.sv
// Scoreboard bench for debug_dump_sink: bus reads and UART frames are checked
// by monitors against queues filled when stimulus is issued.
module tb_debug_dump_sink;

    localparam int          CLKS    = 4;
    localparam int          DEPTH   = 16;
    localparam logic [29:0] DATA_A  = 30'h4000800;
    localparam logic [29:0] STAT_A  = 30'h4000801;
    localparam logic [29:0] UNMAP_A = 30'h0000010;

    logic        CLK_I       = 1'b0;
    logic        reset_n     = 1'b0;
    logic        CYC_I       = 1'b0;
    logic        STB_I       = 1'b0;
    logic        WE_I        = 1'b0;
    logic [29:0] ADR_I       = '0;
    logic [3:0]  SEL_I       = '0;
    logic [31:0] slave_DAT_I = '0;
    logic [31:0] slave_DAT_O;
    logic        ACK_O;
    logic        txd;
    logic        fifo_overflow;

    int          tests_run     = 0;
    int          tests_failed  = 0;
    int          cycle         = 0;
    int          ack_seen      = 0;
    int          acks_expected = 0;
    int          start_cycle   = 0;
    logic        mon_en        = 1'b0;
    logic        ack_prev      = 1'b0;
    logic [7:0]  exp_tx [$];
    logic [31:0] exp_rd [$];

    debug_dump_sink #(
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CLKS),
        .DATA_ADR     (DATA_A),
        .STAT_ADR     (STAT_A)
    ) dut (
        .CLK_I         (CLK_I),
        .reset_n       (reset_n),
        .CYC_I         (CYC_I),
        .STB_I         (STB_I),
        .WE_I          (WE_I),
        .ADR_I         (ADR_I),
        .SEL_I         (SEL_I),
        .slave_DAT_I   (slave_DAT_I),
        .slave_DAT_O   (slave_DAT_O),
        .ACK_O         (ACK_O),
        .txd           (txd),
        .fifo_overflow (fifo_overflow)
    );

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic busIdle();
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        ADR_I = '0; SEL_I = '0; slave_DAT_I = '0;
    endtask

    // One bus access; returns the cycle in which ACK_O was first seen.
    task automatic applyStimulus(input logic we, input logic [29:0] adr,
                                 input logic [3:0] sel, input logic [31:0] dat,
                                 output int ack_cycle);
        int waited;
        waited = 0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we;
        ADR_I = adr; SEL_I = sel; slave_DAT_I = dat;
        acks_expected++;
        @(posedge CLK_I); #1; waited++;
        while (!ACK_O && waited < 200) begin
            @(posedge CLK_I); #1; waited++;
        end
        if (!ACK_O) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL ack_timeout: got no ACK after %0d cycles, expected one", waited);
        end
        ack_cycle = cycle;
        @(posedge CLK_I); #1;
        busIdle();
    endtask

    task automatic readReg(input logic [29:0] adr, input logic [31:0] expected);
        int c;
        exp_rd.push_back(expected);
        applyStimulus(1'b0, adr, 4'b1111, 32'h0, c);
    endtask

    task automatic writeData(input logic [7:0] b, output int ack_cycle);
        exp_tx.push_back(b);
        applyStimulus(1'b1, DATA_A, 4'b1111, {b, 24'h0}, ack_cycle);
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while (exp_tx.size() != 0 && w < 2000) begin
            @(posedge CLK_I); #1; w++;
        end
        if (exp_tx.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_tx.size());
        end
        repeat (4) @(posedge CLK_I);
        #1;
    endtask

    // Bus monitor: every ACK must be one cycle wide; read ACKs pop the read queue.
    always @(negedge CLK_I) begin
        if (mon_en) begin
            if (ACK_O) begin
                ack_seen++;
                checkOutput("ack_pulse_width", {31'b0, ack_prev}, 32'h0);
                if (!WE_I) begin
                    if (exp_rd.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_read_ack: got data %h, expected no read", slave_DAT_O);
                    end else begin
                        checkOutput("read_data", slave_DAT_O, exp_rd.pop_front());
                    end
                end
            end
            ack_prev = ACK_O;
        end
    end

    // UART monitor: captures 10 bit times cycle by cycle from the first low sample.
    initial begin : tx_monitor
        logic       s [10*CLKS];
        logic [7:0] got;
        logic       shape_ok;
        logic       aborted;
        forever begin
            @(posedge CLK_I); #1;
            if (mon_en && reset_n && txd === 1'b0) begin
                start_cycle = cycle;
                aborted     = 1'b0;
                s[0]        = txd;
                for (int i = 1; i < 10*CLKS; i++) begin
                    @(posedge CLK_I); #1;
                    if (!reset_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = txd;
                end
                if (aborted) begin
                    if (exp_tx.size() != 0) void'(exp_tx.pop_front());
                end else begin
                    shape_ok = 1'b1;
                    for (int b = 0; b < 10; b++)
                        for (int j = 1; j < CLKS; j++)
                            if (s[b*CLKS+j] !== s[b*CLKS]) shape_ok = 1'b0;
                    for (int k = 0; k < 8; k++) got[k] = s[(k+1)*CLKS];
                    if (exp_tx.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_frame: got byte %h, expected no frame", got);
                    end else begin
                        checkOutput("tx_byte", {24'h0, got}, {24'h0, exp_tx.pop_front()});
                        checkOutput("tx_frame_shape", {29'h0, shape_ok, s[0], s[9*CLKS]}, 32'h5);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int         c0;
        int         c1;
        int         c16;
        logic [3:0] pattern;
        logic       any_ack;

        busIdle();
        reset_n = 1'b0;
        repeat (4) @(posedge CLK_I);
        #1;
        checkOutput("reset_txd", {31'b0, txd}, 32'h1);
        checkOutput("reset_ack", {31'b0, ACK_O}, 32'h0);
        checkOutput("reset_overflow", {31'b0, fifo_overflow}, 32'h0);
        checkOutput("reset_dat_o", slave_DAT_O, 32'h0);
        @(negedge CLK_I);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge CLK_I); #1;

        $display("[TB] reset status");
        readReg(STAT_A, 32'h0000_0001);

        $display("[TB] single byte");
        writeData(8'hA5, c0);
        checkOutput("ack_count_single", ack_seen, acks_expected);
        waitDrain();
        checkOutput("start_latency", start_cycle - c0, 32'd1);
        checkOutput("idle_txd", {31'b0, txd}, 32'h1);

        $display("[TB] fill and stall");
        for (int k = 0; k < 17; k++) begin
            writeData(8'h10 + 8'(k), c1);
            if (k == 0)  c0  = c1;
            if (k == 16) c16 = c1;
        end
        writeData(8'h21, c1);
        checkOutput("fill_no_stall", c16 - c0, 32'd32);
        checkOutput("stall_release", c1 - c0, 32'd42);
        waitDrain();
        readReg(STAT_A, 32'h0000_0001);

        $display("[TB] overflow");
        for (int k = 0; k < 17; k++) writeData(8'h40 + 8'(k), c1);
        readReg(STAT_A, 32'h0000_1006);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
        ADR_I = DATA_A; SEL_I = 4'b1111; slave_DAT_I = 32'hEE00_0000;
        any_ack = 1'b0;
        repeat (3) begin
            @(posedge CLK_I); #1;
            any_ack = any_ack | ACK_O;
        end
        checkOutput("stall_no_ack", {31'b0, any_ack}, 32'h0);
        busIdle();
        @(posedge CLK_I); #1;
        checkOutput("overflow_set", {31'b0, fifo_overflow}, 32'h1);
        waitDrain();
        readReg(STAT_A, 32'h0000_0009);
        applyStimulus(1'b1, STAT_A, 4'b1111, 32'h0000_0008, c1);
        checkOutput("overflow_cleared", {31'b0, fifo_overflow}, 32'h0);
        readReg(STAT_A, 32'h0000_0001);

        $display("[TB] edge cases");
        readReg(UNMAP_A, 32'h0);
        readReg(DATA_A, 32'h0);
        applyStimulus(1'b1, DATA_A, 4'b0111, 32'h7700_0000, c1);
        applyStimulus(1'b1, UNMAP_A, 4'b1111, 32'hFFFF_FFFF, c1);
        readReg(STAT_A, 32'h0000_0001);
        exp_rd.push_back(32'h0000_0001);
        exp_rd.push_back(32'h0000_0001);
        acks_expected += 2;
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0;
        ADR_I = STAT_A; SEL_I = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK_I); #1;
            pattern[3-i] = ACK_O;
        end
        busIdle();
        checkOutput("stb_held_ack_pattern", {28'h0, pattern}, 32'hA);
        repeat (2) @(posedge CLK_I);
        #1;

        $display("[TB] reset mid-frame");
        writeData(8'hC3, c0);
        while (cycle < c0 + 18) begin
            @(posedge CLK_I); #1;
        end
        checkOutput("txd_bit3_before_reset", {31'b0, txd}, 32'h0);
        @(negedge CLK_I);
        reset_n = 1'b0;
        @(posedge CLK_I); #1;
        checkOutput("txd_after_reset", {31'b0, txd}, 32'h1);
        repeat (2) @(posedge CLK_I);
        @(negedge CLK_I);
        reset_n = 1'b1;
        @(posedge CLK_I); #1;
        readReg(STAT_A, 32'h0000_0001);
        repeat (100) @(posedge CLK_I);
        #1;
        checkOutput("tx_queue_empty", exp_tx.size(), 32'd0);
        checkOutput("read_queue_empty", exp_rd.size(), 32'd0);
        checkOutput("ack_count_total", ack_seen, acks_expected);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
